// File: rtl/ex_muldiv_unit_if.sv
// Handshake and HI/LO bus between the EX stage and the multiply/divide unit.
// The pipeline side drives the master modport; the unit itself uses slave.
interface ex_muldiv_unit_if #(parameter int NBits = 32);
    logic             in_Start;
    logic [2:0]       in_Op;
    logic [NBits-1:0] in_A;
    logic [NBits-1:0] in_B;
    logic             in_Flush;
    logic             out_Busy;
    logic             out_Done;
    logic [NBits-1:0] out_HI;
    logic [NBits-1:0] out_LO;

    modport master (
        output in_Start, in_Op, in_A, in_B, in_Flush,
        input  out_Busy, out_Done, out_HI, out_LO
    );

    modport slave (
        input  in_Start, in_Op, in_A, in_B, in_Flush,
        output out_Busy, out_Done, out_HI, out_LO
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO: 32-step shift-add multiply and
// restoring divide on sign magnitudes, with sign fix-up in a final step.
module ex_muldiv_unit #(
    parameter int NBits = 32
) (
    input logic            clk,
    input logic            reset,
    ex_muldiv_unit_if.slave bus
);
    localparam logic [2:0] IDLE = 3'd0, MUL = 3'd1, DIV = 3'd2, FIX = 3'd3, DONE = 3'd4;
    localparam logic [2:0] OP_MULT = 3'b000, OP_MULTU = 3'b001, OP_DIV = 3'b010,
                           OP_DIVU = 3'b011, OP_MTHI = 3'b100, OP_MTLO = 3'b101;

    logic [2:0]         state;
    logic [5:0]         count;
    logic [2*NBits-1:0] acc;      // MUL: {partial product, multiplier}; DIV: low half is dividend/quotient
    logic [NBits-1:0]   rem;
    logic [NBits-1:0]   regB;
    logic [NBits-1:0]   hi, lo;
    logic               signA, signB, isSigned, isDiv, divZero;

    logic               signedOp;
    logic [NBits-1:0]   magA, magB;
    logic [NBits:0]     mulSum;
    logic [NBits:0]     partRem, partDiff;
    logic [2*NBits-1:0] prod;
    logic [NBits-1:0]   fixHi, fixLo;

    always_comb begin
        signedOp = (bus.in_Op == OP_MULT) || (bus.in_Op == OP_DIV);
        magA     = (signedOp && bus.in_A[NBits-1]) ? -bus.in_A : bus.in_A;
        magB     = (signedOp && bus.in_B[NBits-1]) ? -bus.in_B : bus.in_B;
        mulSum   = {1'b0, acc[2*NBits-1:NBits]} + (acc[0] ? {1'b0, regB} : {(NBits+1){1'b0}});
        partRem  = {rem, acc[NBits-1]};
        partDiff = partRem - {1'b0, regB};
        prod     = (isSigned && (signA ^ signB)) ? -acc : acc;
        fixHi    = prod[2*NBits-1:NBits];
        fixLo    = prod[NBits-1:0];
        if (isDiv) begin
            if (divZero) begin
                // Dividend magnitude is still parked in acc; rebuild the raw operand.
                fixLo = {NBits{1'b1}};
                fixHi = (isSigned && signA) ? -acc[NBits-1:0] : acc[NBits-1:0];
            end else begin
                fixLo = (isSigned && (signA ^ signB)) ? -acc[NBits-1:0] : acc[NBits-1:0];
                fixHi = (isSigned && signA) ? -rem : rem;
            end
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= '0;
            acc      <= '0;
            rem      <= '0;
            regB     <= '0;
            hi       <= '0;
            lo       <= '0;
            signA    <= 1'b0;
            signB    <= 1'b0;
            isSigned <= 1'b0;
            isDiv    <= 1'b0;
            divZero  <= 1'b0;
        end else if (bus.in_Flush) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_Start) begin
                    case (bus.in_Op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            acc      <= {{NBits{1'b0}}, magA};
                            regB     <= magB;
                            rem      <= '0;
                            count    <= '0;
                            signA    <= signedOp & bus.in_A[NBits-1];
                            signB    <= signedOp & bus.in_B[NBits-1];
                            isSigned <= signedOp;
                            isDiv    <= bus.in_Op[1];
                            divZero  <= bus.in_Op[1] && (bus.in_B == '0);
                            if (!bus.in_Op[1])         state <= MUL;
                            else if (bus.in_B == '0)   state <= FIX;
                            else                       state <= DIV;
                        end
                        OP_MTHI: hi <= bus.in_A;
                        OP_MTLO: lo <= bus.in_A;
                        default: ;
                    endcase
                end
                MUL: begin
                    acc   <= {mulSum, acc[NBits-1:1]};
                    count <= count + 6'd1;
                    if (count == 6'(NBits-1)) state <= FIX;
                end
                DIV: begin
                    // Negative trial difference means restore: keep the shifted remainder.
                    rem            <= partDiff[NBits] ? partRem[NBits-1:0] : partDiff[NBits-1:0];
                    acc[NBits-1:0] <= {acc[NBits-2:0], ~partDiff[NBits]};
                    count          <= count + 6'd1;
                    if (count == 6'(NBits-1)) state <= FIX;
                end
                FIX: begin
                    hi    <= fixHi;
                    lo    <= fixLo;
                    count <= '0;
                    state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out_Busy = (state == MUL) || (state == DIV) || (state == FIX);
    assign bus.out_Done = (state == DONE);
    assign bus.out_HI   = hi;
    assign bus.out_LO   = lo;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: table of mul/div vectors through a scoreboard,
// plus hand sequences for MTHI/MTLO, flush and mid-operation reset.
module tb_ex_muldiv_unit;
    logic clk = 1'b1;
    logic reset = 1'b0;

    ex_muldiv_unit_if #(.NBits(32)) bus();
    ex_muldiv_unit #(.NBits(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, hi, lo;
        int          lat, busy;
        bit          hold;
    } vec_t;

    typedef struct {
        logic [31:0] hi, lo;
        int          lat, busy;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[10];
    int          checks = 0, errors = 0;
    logic [31:0] lastHi = '0, lastLo = '0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic runVec(input vec_t v, input int idx);
        int   edges, busyCnt;
        bit   seen, stable;
        exp_t e;
        @(posedge clk);
        bus.in_Start = 1'b1; bus.in_Op = v.op; bus.in_A = v.a; bus.in_B = v.b;
        sb.push_back('{v.hi, v.lo, v.lat, v.busy});
        edges = 0; busyCnt = 0; seen = 0; stable = 1;
        while (!seen && edges < 100) begin
            @(posedge clk);
            edges++;
            if (!v.hold) bus.in_Start = 1'b0;
            if (bus.out_Busy) busyCnt++;
            if (bus.out_Done) seen = 1;
            else if (bus.out_HI !== lastHi || bus.out_LO !== lastLo) stable = 0;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL vec%0d_timeout: no out_Done within %0d edges", idx, edges);
            void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            check32($sformatf("vec%0d_hi", idx), bus.out_HI, e.hi);
            check32($sformatf("vec%0d_lo", idx), bus.out_LO, e.lo);
            check32($sformatf("vec%0d_latency", idx), 32'(edges), 32'(e.lat));
            check32($sformatf("vec%0d_busycycles", idx), 32'(busyCnt), 32'(e.busy));
            check32($sformatf("vec%0d_hilo_stable", idx), {31'b0, stable}, 32'd1);
        end
        lastHi = v.hi; lastLo = v.lo;
        if (v.hold) begin
            // in_Start stayed high across the DONE edge; it must not restart.
            @(posedge clk);
            check32($sformatf("vec%0d_done_rejects_start", idx), {31'b0, bus.out_Busy}, 32'd0);
            check32($sformatf("vec%0d_done_single", idx), {31'b0, bus.out_Done}, 32'd0);
        end
        bus.in_Start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busySeen, doneSeen;
        bus.in_Start = 1'b0; bus.in_Op = 3'b110; bus.in_A = '0; bus.in_B = '0; bus.in_Flush = 1'b0;
        #2;
        check32("reset_hi", bus.out_HI, 32'h0);
        check32("reset_lo", bus.out_LO, 32'h0);
        check32("reset_busy", {31'b0, bus.out_Busy}, 32'd0);
        check32("reset_done", {31'b0, bus.out_Done}, 32'd0);
        #5 reset = 1'b1;

        vecs[0] = '{3'b000, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 34, 33, 1'b0};
        vecs[1] = '{3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 34, 33, 1'b0};
        vecs[2] = '{3'b011, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 34, 33, 1'b0};
        vecs[3] = '{3'b011, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 2, 1, 1'b0};
        vecs[4] = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 34, 33, 1'b0};
        vecs[5] = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34, 33, 1'b0};
        vecs[6] = '{3'b000, 32'h00000007, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFDD, 34, 33, 1'b0};
        vecs[7] = '{3'b010, 32'h00000064, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 34, 33, 1'b0};
        vecs[8] = '{3'b010, 32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF, 2, 1, 1'b0};
        vecs[9] = '{3'b001, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 34, 33, 1'b1};

        for (int i = 0; i < 10; i++) runVec(vecs[i], i);

        // MTHI / MTLO: single-edge writes, no busy, no done
        @(posedge clk); bus.in_Start = 1'b1; bus.in_Op = 3'b100; bus.in_A = 32'hDEADBEEF;
        @(posedge clk); bus.in_Start = 1'b0;
        check32("mthi_hi", bus.out_HI, 32'hDEADBEEF);
        check32("mthi_lo_kept", bus.out_LO, lastLo);
        check32("mthi_busy", {31'b0, bus.out_Busy}, 32'd0);
        check32("mthi_done", {31'b0, bus.out_Done}, 32'd0);
        lastHi = 32'hDEADBEEF;
        bus.in_Start = 1'b1; bus.in_Op = 3'b101; bus.in_A = 32'h0BADF00D;
        @(posedge clk); bus.in_Start = 1'b0;
        check32("mtlo_lo", bus.out_LO, 32'h0BADF00D);
        check32("mtlo_hi_kept", bus.out_HI, lastHi);
        check32("mtlo_done", {31'b0, bus.out_Done}, 32'd0);
        lastLo = 32'h0BADF00D;

        // Flush beats an MTHI on the same edge
        @(posedge clk); bus.in_Start = 1'b1; bus.in_Op = 3'b100; bus.in_A = 32'h11111111; bus.in_Flush = 1'b1;
        @(posedge clk); bus.in_Start = 1'b0; bus.in_Flush = 1'b0;
        check32("flush_mthi_hi", bus.out_HI, lastHi);

        // Flush at MULT iteration 10 with a competing start
        @(posedge clk); bus.in_Start = 1'b1; bus.in_Op = 3'b000; bus.in_A = 32'd3; bus.in_B = 32'd4;
        @(posedge clk); bus.in_Start = 1'b0;
        check32("flush_mult_started", {31'b0, bus.out_Busy}, 32'd1);
        repeat (9) @(posedge clk);
        bus.in_Flush = 1'b1; bus.in_Start = 1'b1; bus.in_Op = 3'b001; bus.in_A = 32'd5; bus.in_B = 32'd6;
        @(posedge clk); bus.in_Flush = 1'b0; bus.in_Start = 1'b0;
        check32("flush_busy", {31'b0, bus.out_Busy}, 32'd0);
        check32("flush_hi", bus.out_HI, lastHi);
        check32("flush_lo", bus.out_LO, lastLo);
        busySeen = 0; doneSeen = 0;
        repeat (40) begin
            @(posedge clk);
            if (bus.out_Busy) busySeen++;
            if (bus.out_Done) doneSeen++;
        end
        check32("flush_no_capture", 32'(busySeen), 32'd0);
        check32("flush_no_done", 32'(doneSeen), 32'd0);
        check32("flush_hi_after", bus.out_HI, lastHi);

        // Reset at DIV iteration 20, then MTLO on the first edge after release
        @(posedge clk); bus.in_Start = 1'b1; bus.in_Op = 3'b010; bus.in_A = 32'd1000; bus.in_B = 32'd3;
        @(posedge clk); bus.in_Start = 1'b0;
        repeat (19) @(posedge clk);
        reset = 1'b0;
        #1;
        check32("midreset_hi", bus.out_HI, 32'h0);
        check32("midreset_lo", bus.out_LO, 32'h0);
        check32("midreset_busy", {31'b0, bus.out_Busy}, 32'd0);
        check32("midreset_done", {31'b0, bus.out_Done}, 32'd0);
        @(posedge clk);
        reset = 1'b1; bus.in_Start = 1'b1; bus.in_Op = 3'b101; bus.in_A = 32'hA5A5A5A5;
        @(posedge clk); bus.in_Start = 1'b0;
        check32("postreset_mtlo", bus.out_LO, 32'hA5A5A5A5);
        check32("postreset_hi", bus.out_HI, 32'h0);
        check32("postreset_busy", {31'b0, bus.out_Busy}, 32'd0);

        check32("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_muldiv_unit.md
EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

Interface
REQ-001 The block SHALL have parameter NBits, default 32, giving operand and HI/LO width; only 32 is supported.
REQ-002 The block SHALL have input clk, 1 bit, the pipeline clock; all state SHALL update on the falling edge, matching the pipeline registers.
REQ-003 The block SHALL have input reset, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have input in_Start, 1 bit, which requests an operation from the ID/EX stage outputs.
REQ-005 The block SHALL have input in_Op, 3 bits, encoded as 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, with 110 and 111 as no-op.
REQ-006 The block SHALL have input in_A, NBits wide, carrying operand rs (ID/EX ReadData1).
REQ-007 The block SHALL have input in_B, NBits wide, carrying operand rt (ID/EX ReadData2).
REQ-008 The block SHALL have input in_Flush, 1 bit, which aborts any operation in flight.
REQ-009 The block SHALL have output out_Busy, 1 bit, the stall request to the hazard unit and pipeline registers.
REQ-010 The block SHALL have output out_Done, 1 bit, a one-cycle completion pulse.
REQ-011 The block SHALL have output out_HI, NBits wide, the architectural HI register.
REQ-012 The block SHALL have output out_LO, NBits wide, the architectural LO register.

Function
REQ-013 The FSM SHALL have the states IDLE, MUL, DIV, FIX and DONE.
REQ-014 In IDLE, a falling edge with in_Start=1 and in_Op in MULT/MULTU SHALL capture the operands and enter MUL; with DIV/DIVU it SHALL enter DIV.
REQ-015 For signed ops the block SHALL capture the magnitudes of in_A and in_B plus both sign bits; unsigned ops SHALL capture the raw operands.
REQ-016 MUL SHALL run radix-2 shift-add over a 64-bit accumulator for exactly 32 edges, using a 6-bit counter, then enter FIX.
REQ-017 DIV SHALL run restoring division for exactly 32 edges, one quotient bit per edge with a 33-bit partial remainder, then enter FIX.
REQ-018 FIX SHALL, for one edge, apply sign correction and write HI/LO, then enter DONE.
REQ-019 Multiply results SHALL be {HI,LO} = the 64-bit product, negated if the operand signs differ (MULT only).
REQ-020 Divide results SHALL be LO=quotient and HI=remainder; for DIV the quotient is negated if the signs differ and the remainder takes the sign of the dividend.
REQ-021 DIV of 0x80000000 by 0xFFFFFFFF SHALL yield LO=0x80000000 and HI=0.
REQ-022 A divisor of zero (DIV or DIVU) SHALL skip iteration and go IDLE->FIX, with FIX writing LO=0xFFFFFFFF and HI=in_A.
REQ-023 DONE SHALL last one cycle with out_Done=1, then return to IDLE; a new in_Start SHALL NOT be accepted in DONE.
REQ-024 out_Busy SHALL be 1 in states MUL, DIV and FIX, and 0 in IDLE and DONE.
REQ-025 Latency from the start edge to the HI/LO update SHALL be 34 edges for MUL and DIV, and 2 edges for divide-by-zero.
REQ-026 MTHI/MTLO in IDLE with in_Start=1 SHALL write in_A to HI or LO on that edge, with no busy and no done pulse.
REQ-027 in_Start SHALL be ignored while not in IDLE.
REQ-028 in_Flush=1 SHALL force IDLE on the next edge, leave HI/LO unchanged and suppress out_Done.
REQ-029 in_Flush SHALL have priority over in_Start on the same edge, so no capture and no MTHI/MTLO write occur.
REQ-030 HI/LO SHALL change only on the FIX edge or on an MTHI/MTLO edge.

Reset
REQ-031 reset=0 SHALL immediately force IDLE and zero out_HI, out_LO, the counter and all operand registers.
REQ-032 During reset=0, out_Busy and out_Done SHALL be 0.
REQ-033 Reset asserted mid-operation SHALL discard the operation with no partial HI/LO write.
REQ-034 The first falling edge after reset deasserts SHALL be able to accept in_Start.

Verification
REQ-035 The bench SHALL drive MULT with A=0xFFFFFFFE (-2) and B=0x00000003, and require HI=0xFFFFFFFF, LO=0xFFFFFFFA, out_Done exactly 34 edges after start, and out_Busy for 33 cycles.
REQ-036 The bench SHALL drive DIV with A=0xFFFFFFF9 (-7) and B=2, and require LO=0xFFFFFFFD and HI=0xFFFFFFFF; then DIVU with A=7 and B=2, and require LO=3 and HI=1.
REQ-037 The bench SHALL drive DIVU with A=0x12345678 and B=0, and require LO=0xFFFFFFFF, HI=0x12345678, and out_Done 2 edges after start.
REQ-038 The bench SHALL drive MULTU with A=0xFFFFFFFF and B=0xFFFFFFFF, and require HI=0xFFFFFFFE and LO=0x00000001.
REQ-039 The bench SHALL start MULT, pulse in_Flush at iteration 10 with in_Start=1, and require IDLE, HI/LO unchanged, no out_Done, and no new capture.
REQ-040 The bench SHALL assert reset at iteration 20 of a DIV and require HI=LO=0, out_Busy=0 immediately, and a fresh MTLO of 0xA5A5A5A5 to set LO on the next edge.
